// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and constants for the mmio_ctrl memory/I-O controller.
//   - state_e        response channel state (IDLE: nothing held, RESP: load data held)
//   - IO_SEL_BIT     address bit selecting I/O space over RAM
//   - IDX_*          I/O register index field and the fixed register indices
//   - STATUS_*       field positions inside the STATUS register
package mmio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam int unsigned IO_SEL_BIT = 31;

    // I/O register index is the word offset req_addr[7:2].
    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned IDX_W   = 6;

    localparam logic [IDX_W-1:0] IDX_CYCLE  = 6'd62;
    localparam logic [IDX_W-1:0] IDX_STATUS = 6'd63;

    localparam int unsigned CYCLE_W = 32;

    localparam int unsigned STATUS_ERR_BIT  = 0;
    localparam int unsigned STATUS_NOUT_LSB = 8;
    localparam int unsigned STATUS_NOUT_W   = 8;

endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous RAM with per-byte write enables and a
// registered read port, written so synthesis maps it onto block RAM.
//   clk      clock
//   en_i     access this cycle
//   we_i     1 = write, 0 = read
//   be_i     byte enables for writes
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data, valid the cycle after a read; holds between reads
module data_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the array and its read register have no reset; a reset port would
    // prevent mapping onto block RAM, and the controller masks the read data
    // until a RAM load has completed.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                // Only reads update the output register, so a held response
                // stays stable even if later accesses are stores.
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: decodes core load/store requests onto a data RAM (addr[31]=0) or
// an I/O register bank (addr[31]=1: OUT[0..N_OUT-1], CYCLE, STATUS) and returns
// load data over a valid/ready response channel with one-cycle latency.
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_we/addr/wdata/be        store flag, byte address, store data, byte enables
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/rsp_err           load data, unmapped-load flag
//   data_out                    concatenated OUT registers, port i at [i*OUT_WIDTH +: OUT_WIDTH]
// DATA_WIDTH is assumed to be at least 32 so CYCLE and STATUS fit in one word.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 8,
    parameter int unsigned N_OUT          = 2,
    parameter int unsigned OUT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [31:0]                 req_addr,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    input  logic [DATA_WIDTH/8-1:0]     req_be,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic [N_OUT*OUT_WIDTH-1:0]  data_out
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    state_e                        state_q;
    logic                          rsp_err_q, rsp_from_ram_q;
    logic [DATA_WIDTH-1:0]         io_rdata_q, io_rdata_d;
    logic [N_OUT-1:0][OUT_WIDTH-1:0] out_q, out_d;
    logic [CYCLE_W-1:0]            cycle_q, cycle_d;
    logic                          err_q, err_d;

    logic                          is_io, io_mapped, accept, load;
    logic [IDX_W-1:0]              io_idx;
    logic [DATA_WIDTH-1:0]         byte_mask, ram_rdata;

    // Byte-enable merge shared by OUT and CYCLE stores.
    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                    input logic [DATA_WIDTH-1:0] new_v,
                                                    input logic [DATA_WIDTH-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign is_io     = req_addr[IO_SEL_BIT];
    assign io_idx    = req_addr[IDX_LSB +: IDX_W];
    assign rsp_valid = (state_q == RESP);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign load      = accept && !req_we;

    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results; clocked blocks use '<=' so every flop samples pre-edge values.
    always_comb begin
        for (int b = 0; b < NBYTES; b++) begin
            byte_mask[b*8 +: 8] = {8{req_be[b]}};
        end
    end

    // I/O read mux and decode.
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        io_rdata_d = '0;
        io_mapped  = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (io_idx == IDX_W'(i)) begin
                io_mapped  = 1'b1;
                io_rdata_d = DATA_WIDTH'(out_q[i]);
            end
        end
        if (io_idx == IDX_CYCLE) begin
            io_mapped  = 1'b1;
            io_rdata_d = DATA_WIDTH'(cycle_q);
        end
        if (io_idx == IDX_STATUS) begin
            io_mapped = 1'b1;
            io_rdata_d[STATUS_ERR_BIT] = err_q;
            io_rdata_d[STATUS_NOUT_LSB +: STATUS_NOUT_W] = STATUS_NOUT_W'(N_OUT);
        end
    end

    // Register bank next state. A CYCLE store overrides the increment.
    always_comb begin
        out_d   = out_q;
        cycle_d = cycle_q + CYCLE_W'(1);
        err_d   = err_q;
        if (accept && is_io) begin
            if (!io_mapped) begin
                err_d = 1'b1;
            end else if (req_we) begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (io_idx == IDX_W'(i)) begin
                        out_d[i] = OUT_WIDTH'(merge(DATA_WIDTH'(out_q[i]), req_wdata, byte_mask));
                    end
                end
                if (io_idx == IDX_CYCLE) begin
                    cycle_d = CYCLE_W'(merge(DATA_WIDTH'(cycle_q), req_wdata, byte_mask));
                end
                if (io_idx == IDX_STATUS && req_be[0] && req_wdata[STATUS_ERR_BIT]) begin
                    err_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            cycle_q <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            cycle_q <= cycle_d;
            err_q   <= err_d;
        end
    end

    // Response FSM. A load can only be accepted in RESP when rsp_ready is high,
    // so "load accepted" covers both IDLE->RESP and the back-to-back RESP->RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rsp_err_q      <= 1'b0;
            rsp_from_ram_q <= 1'b0;
            io_rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready && !load) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (load) begin
                rsp_from_ram_q <= !is_io;
                io_rdata_q     <= io_rdata_d;
                rsp_err_q      <= is_io && !io_mapped;
            end
        end
    end

    data_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_data_ram (
        .clk     (clk),
        .en_i    (accept && !is_io),
        .we_i    (req_we),
        .be_i    (req_be),
        .addr_i  (req_addr[2 +: RAM_ADDR_WIDTH]),
        .wdata_i (req_wdata),
        .rdata_o (ram_rdata)
    );

    assign rsp_rdata = rsp_from_ram_q ? ram_rdata : io_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign data_out  = out_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed scenarios plus a randomized run
// scored against a behavioural model (arrays for RAM/OUT, a counter for CYCLE,
// a queue of expected load responses).
module tb_mmio_ctrl;

    localparam int N_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    logic [31:0] ram_m [256];
    logic [15:0] out_m [N_OUT];
    logic        err_m;
    logic [31:0] cyc_m;
    logic [32:0] exp_q [$];   // {err, data} of loads still owed a response

    always #5 clk = ~clk;

    mmio_ctrl #(
        .DATA_WIDTH(32), .RAM_ADDR_WIDTH(8), .N_OUT(N_OUT), .OUT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .data_out(data_out)
    );

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) o[b*8 +: 8] = n[b*8 +: 8];
        return o;
    endfunction

    function automatic logic [31:0] out_model();
        logic [31:0] v;
        for (int i = 0; i < N_OUT; i++) v[i*16 +: 16] = out_m[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_OUT; i++) out_m[i] = '0;
        err_m = 1'b0;
        cyc_m = '0;
        exp_q.delete();
    endfunction

    function automatic logic [32:0] model_read(input logic [31:0] a);
        int idx;
        if (!a[31]) return {1'b0, ram_m[a[9:2]]};
        idx = int'(a[7:2]);
        if (idx < N_OUT) return {17'h0, out_m[idx]};
        if (idx == 62) return {1'b0, cyc_m};
        if (idx == 63) return {17'h0, 8'(N_OUT), 7'h0, err_m};
        err_m = 1'b1;
        return {1'b1, 32'h0};
    endfunction

    // Returns 1 when the store loaded CYCLE (so it does not increment).
    function automatic bit model_write(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] be);
        int idx;
        if (!a[31]) begin
            ram_m[a[9:2]] = bmerge(ram_m[a[9:2]], d, be);
            return 1'b0;
        end
        idx = int'(a[7:2]);
        if (idx < N_OUT) out_m[idx] = 16'(bmerge({16'h0, out_m[idx]}, d, be));
        else if (idx == 62) begin
            cyc_m = bmerge(cyc_m, d, be);
            return 1'b1;
        end
        else if (idx == 63) begin
            if (be[0] && d[0]) err_m = 1'b0;
        end
        else err_m = 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive at posedge+1, sample 1ns later, advance model on the edge.
    task automatic step(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic rr,
                        output logic acc, output logic rv, output logic got,
                        output logic [31:0] rd, output logic re, output logic [32:0] exp);
        bit cyc_loaded;
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be; rsp_ready = rr;
        #1;
        acc = v && req_ready;
        rv  = rsp_valid;
        got = rsp_valid && rr;
        rd  = rsp_rdata;
        re  = rsp_err;
        exp = 'x;
        if (got && exp_q.size() > 0) exp = exp_q.pop_front();
        cyc_loaded = 1'b0;
        if (acc) begin
            if (!we) exp_q.push_back(model_read(a));
            else cyc_loaded = model_write(a, d, be);
        end
        if (!cyc_loaded) cyc_m = cyc_m + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic acc, rv, got, re; logic [31:0] rd; logic [32:0] exp;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp: got %h/%b want 0/0", rsp_rdata, rsp_err); end
        rst_n = 1'b1;
        model_reset();
        repeat (10) step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL idle_data_out: got %h want 0", data_out); end
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_hs: got v=%b r=%b want 0/1", rsp_valid, req_ready); end
        step(1, 0, 32'h8000_00F8, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL cyc_load_acc: got %b want 1", acc); end
        step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (got !== 1'b1 || rd < 32'd9 || rd > 32'd11) begin n_bad++; $display("FAIL cyc_after_idle: got valid=%b %0d want 10+-1", got, rd); end
        n_cmp++; if (rd !== exp[31:0]) begin n_bad++; $display("FAIL cyc_model: got %0d want %0d", rd, exp[31:0]); end
    endtask

    task automatic test_ram();
        logic acc, rv, got, re; logic [31:0] rd; logic [32:0] exp;
        step(1, 1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1, acc, rv, got, rd, re, exp);
        step(1, 1, 32'h0000_0040, 32'h0000_1200, 4'h2, 1, acc, rv, got, rd, re, exp);
        step(1, 0, 32'h0000_0040, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (acc !== 1'b1 || rv !== 1'b0) begin n_bad++; $display("FAIL ram_load_acc: got acc=%b rv=%b want 1/0", acc, rv); end
        step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (got !== 1'b1 || rd !== 32'hDEAD_12EF || re !== 1'b0) begin n_bad++; $display("FAIL ram_be_merge: got v=%b %h err=%b want 1 DEAD12EF 0", got, rd, re); end
    endtask

    task automatic test_out();
        logic acc, rv, got, re; logic [31:0] rd; logic [32:0] exp;
        step(1, 1, 32'h8000_0004, 32'h0001_ABCD, 4'hF, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (data_out !== 32'hABCD_0000) begin n_bad++; $display("FAIL out1_store: got %h want ABCD0000", data_out); end
        step(1, 0, 32'h8000_0004, 0, 0, 1, acc, rv, got, rd, re, exp);
        step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (got !== 1'b1 || rd !== 32'h0000_ABCD) begin n_bad++; $display("FAIL out1_load: got v=%b %h want 1 0000ABCD", got, rd); end
    endtask

    task automatic test_unmapped();
        logic acc, rv, got, re; logic [31:0] rd; logic [32:0] exp;
        step(1, 0, 32'h8000_0080, 0, 0, 1, acc, rv, got, rd, re, exp);
        step(1, 0, 32'h8000_00FC, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (got !== 1'b1 || rd !== 32'h0 || re !== 1'b1) begin n_bad++; $display("FAIL unmapped_load: got v=%b %h err=%b want 1 0 1", got, rd, re); end
        step(1, 1, 32'h8000_00FC, 32'h1, 4'h1, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (got !== 1'b1 || rd !== 32'h0000_0201 || re !== 1'b0) begin n_bad++; $display("FAIL status_err_set: got v=%b %h err=%b want 1 201 0", got, rd, re); end
        step(1, 0, 32'h8000_00FC, 0, 0, 1, acc, rv, got, rd, re, exp);
        step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (got !== 1'b1 || rd !== 32'h0000_0200) begin n_bad++; $display("FAIL status_err_clr: got v=%b %h want 1 200", got, rd); end
    endtask

    task automatic test_back_to_back();
        logic acc, rv, got, re, rr; logic [31:0] rd; logic [32:0] exp;
        logic [31:0] vals [4];
        int issued = 0, recv = 0;
        for (int k = 0; k < 4; k++) begin
            vals[k] = $urandom();
            step(1, 1, 32'h200 + 32'(4 * k), vals[k], 4'hF, 1, acc, rv, got, rd, re, exp);
        end
        for (int c = 0; c < 20 && recv < 4; c++) begin
            rr = !(c >= 1 && c <= 3);
            step(issued < 4, 0, 32'h200 + 32'(4 * issued), 0, 0, rr, acc, rv, got, rd, re, exp);
            if (c >= 1 && c <= 3) begin
                n_cmp++; if (acc !== 1'b0 || rv !== 1'b1 || rd !== vals[0]) begin n_bad++; $display("FAIL b2b_stall c=%0d: got acc=%b v=%b %h want 0 1 %h", c, acc, rv, rd, vals[0]); end
            end
            if (acc) issued++;
            if (got) begin
                n_cmp++; if (rd !== vals[recv] || re !== 1'b0) begin n_bad++; $display("FAIL b2b_rsp%0d: got %h want %h", recv, rd, vals[recv]); end
                recv++;
            end
        end
        n_cmp++; if (recv != 4) begin n_bad++; $display("FAIL b2b_count: got %0d responses want 4", recv); end
    endtask

    task automatic test_cycle_wrap();
        logic acc, rv, got, re; logic [31:0] rd; logic [32:0] exp;
        step(1, 1, 32'h8000_00F8, 32'hFFFF_FFFE, 4'hF, 1, acc, rv, got, rd, re, exp);
        repeat (3) step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
        step(1, 0, 32'h8000_00F8, 0, 0, 1, acc, rv, got, rd, re, exp);
        step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (got !== 1'b1 || rd !== 32'h1 || rd !== exp[31:0]) begin n_bad++; $display("FAIL cycle_wrap: got v=%b %h want 1 00000001", got, rd); end
    endtask

    task automatic test_random();
        logic acc, rv, got, re, v, we, rr; logic [31:0] rd, a, t; logic [32:0] exp;
        for (int w = 64; w < 80; w++)
            step(1, 1, 32'(w) << 2, $urandom(), 4'hF, 1, acc, rv, got, rd, re, exp);
        for (int n = 0; n < 400; n++) begin
            t = $urandom();
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = {1'b0, t[30:10], 8'($urandom_range(64, 79)), t[1:0]};
                5, 6:          a = {1'b1, t[30:8], 6'($urandom_range(0, N_OUT - 1)), t[1:0]};
                7:             a = {1'b1, t[30:8], 6'd63, t[1:0]};
                8:             a = {1'b1, t[30:8], 6'($urandom_range(2, 61)), t[1:0]};
                default:       a = {1'b1, t[30:8], 6'd62, t[1:0]};
            endcase
            v  = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            step(v, we, a, $urandom(), 4'($urandom()), rr, acc, rv, got, rd, re, exp);
            n_cmp++; if (acc !== (v && (!rv || rr))) begin n_bad++; $display("FAIL rnd_accept n=%0d: got %b v=%b rv=%b rr=%b", n, acc, v, rv, rr); end
            if (got) begin
                n_cmp++; if ({re, rd} !== exp) begin n_bad++; $display("FAIL rnd_rsp n=%0d: got %b/%h want %b/%h", n, re, rd, exp[32], exp[31:0]); end
            end
            n_cmp++; if (data_out !== out_model()) begin n_bad++; $display("FAIL rnd_data_out n=%0d: got %h want %h", n, data_out, out_model()); end
        end
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
            step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
            if (got) begin
                n_cmp++; if ({re, rd} !== exp) begin n_bad++; $display("FAIL rnd_drain: got %b/%h want %b/%h", re, rd, exp[32], exp[31:0]); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_lost: %0d responses never delivered, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        logic acc, rv, got, re; logic [31:0] rd; logic [32:0] exp;
        step(1, 0, 32'h8000_0000, 0, 0, 0, acc, rv, got, rd, re, exp);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mid_valid: got %b want 1", rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_async_drop: got v=%b r=%b want 0/1", rsp_valid, req_ready); end
        n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL mid_data_out: got %h want 0", data_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0, 1, acc, rv, got, rd, re, exp);
        n_cmp++; if (rv !== 1'b0 || data_out !== 32'h0) begin n_bad++; $display("FAIL post_reset: got v=%b out=%h want 0/0", rv, data_out); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_ram();
        test_out();
        test_unmapped();
        test_back_to_back();
        test_cycle_wrap();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
